// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS generator: waveform modes,
// config register map and the sine table generator.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SIN = 2'd0,
        MODE_SQU = 2'd1,
        MODE_TRI = 2'd2,
        MODE_SAW = 2'd3
    } mode_e;

    localparam logic [1:0] CFG_FREQ  = 2'd0;
    localparam logic [1:0] CFG_PHASE = 2'd1;
    localparam logic [1:0] CFG_MODE  = 2'd2;
    localparam logic [1:0] CFG_DUTY  = 2'd3;

    localparam real PI = 3.14159265358979323846;

    // Offset-binary sine sample: mid-scale plus (mid-scale - 1) * sin, rounded to nearest.
    function automatic int sin_lut_entry(input int idx, input int aw, input int ow);
        real half_r;
        real ang_r;
        half_r = real'(32'd1 << (ow - 32'sd1));
        ang_r  = 2.0 * PI * real'(idx) / real'(32'd1 << aw);
        return $rtoi(half_r + (half_r - 1.0) * $sin(ang_r) + 0.5);
    endfunction

endpackage

// File: rtl/dds_multi_gen_if.sv
// Write-only configuration port of the DDS generator.
interface dds_multi_gen_if #(
    parameter int ACC_W = 16,
    parameter int CH_W  = 1
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_addr;
    logic [ACC_W-1:0] cfg_data;

    modport master (output cfg_wr, cfg_ch, cfg_addr, cfg_data);
    modport slave  (input  cfg_wr, cfg_ch, cfg_addr, cfg_data);
endinterface

// File: rtl/dds_sin_lut.sv
// Registered-output sine ROM; its output register is stage 2 of the sine path.
module dds_sin_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-1:0]  rd_data
);
    localparam int DEPTH = 32'sd1 << LUT_AW;

    logic [OUT_W-1:0] rom_s [DEPTH];
    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_s[i] = OUT_W'(sin_lut_entry(i, LUT_AW, OUT_W));
    end

    // ROM read
    always_comb begin
        data_d = rom_s[addr];
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/dds_multi_gen.sv
// Multi-channel DDS: per-channel accumulator and config, two-stage sample
// pipeline (phase add, then waveform shaping) and global phase sync.
module dds_multi_gen
    import dds_pkg::*;
#(
    parameter int  ACC_W  = 16,
    parameter int  OUT_W  = 8,
    parameter int  LUT_AW = 8,
    parameter int  NCH    = 2,
    localparam int CH_W   = (NCH > 32'sd1) ? $clog2(NCH) : 32'sd1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 sync,
    dds_multi_gen_if.slave       cfg,
    output logic [NCH*OUT_W-1:0] wave_out,
    output logic                 wave_valid
);
    localparam logic [ACC_W-1:0] DUTY_RST = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] WAVE_MAX = '1;

    logic [ACC_W-1:0] acc_q   [NCH];
    logic [ACC_W-1:0] acc_d   [NCH];
    logic [ACC_W-1:0] freq_q  [NCH];
    logic [ACC_W-1:0] freq_d  [NCH];
    logic [ACC_W-1:0] phase_q [NCH];
    logic [ACC_W-1:0] phase_d [NCH];
    logic [ACC_W-1:0] duty_q  [NCH];
    logic [ACC_W-1:0] duty_d  [NCH];
    logic [ACC_W-1:0] p_q     [NCH];
    logic [ACC_W-1:0] p_d     [NCH];
    mode_e            mode_q  [NCH];
    mode_e            mode_d  [NCH];
    mode_e            smode_q [NCH];
    mode_e            smode_d [NCH];
    logic [OUT_W-1:0] oth_q   [NCH];
    logic [OUT_W-1:0] oth_d   [NCH];
    logic [OUT_W-1:0] sin_s   [NCH];
    logic             vld1_q, vld1_d;
    logic             vld2_q, vld2_d;

    // Next state: config decode, accumulators, stage-1 phase add, stage-2 shaping
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            freq_d[k]  = freq_q[k];
            phase_d[k] = phase_q[k];
            duty_d[k]  = duty_q[k];
            mode_d[k]  = mode_q[k];
            // Out-of-range channel numbers match no k and are dropped here.
            case ({cfg.cfg_wr && (cfg.cfg_ch == CH_W'(k)), cfg.cfg_addr})
                {1'b1, CFG_FREQ}:  freq_d[k]  = cfg.cfg_data;
                {1'b1, CFG_PHASE}: phase_d[k] = cfg.cfg_data;
                {1'b1, CFG_MODE}:  mode_d[k]  = mode_e'(cfg.cfg_data[1:0]);
                {1'b1, CFG_DUTY}:  duty_d[k]  = cfg.cfg_data;
                default:           ;
            endcase

            if (sync) begin
                acc_d[k] = '0;
            end else if (en) begin
                acc_d[k] = acc_q[k] + freq_q[k];
            end else begin
                acc_d[k] = acc_q[k];
            end

            p_d[k]     = acc_q[k] + phase_q[k];
            smode_d[k] = mode_q[k];

            case (mode_q[k])
                MODE_SQU: oth_d[k] = (p_q[k] < duty_q[k]) ? WAVE_MAX : '0;
                MODE_TRI: oth_d[k] = p_q[k][ACC_W-1] ? ~p_q[k][ACC_W-2 -: OUT_W]
                                                     :  p_q[k][ACC_W-2 -: OUT_W];
                MODE_SAW: oth_d[k] = p_q[k][ACC_W-1 -: OUT_W];
                default:  oth_d[k] = '0;
            endcase
        end
        vld1_d = en;
        vld2_d = vld1_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k]   <= '0;
                freq_q[k]  <= '0;
                phase_q[k] <= '0;
                duty_q[k]  <= DUTY_RST;
                mode_q[k]  <= MODE_SIN;
                smode_q[k] <= MODE_SIN;
                p_q[k]     <= '0;
                oth_q[k]   <= '0;
            end
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
            mode_q  <= mode_d;
            smode_q <= smode_d;
            p_q     <= p_d;
            oth_q   <= oth_d;
            vld1_q  <= vld1_d;
            vld2_q  <= vld2_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        dds_sin_lut #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) u_lut (
            .clk     (clk),
            .rstn    (rstn),
            .addr    (p_q[k][ACC_W-1 -: LUT_AW]),
            .rd_data (sin_s[k])
        );
    end

    // Select the stage-2 register matching the mode that produced this sample
    always_comb begin
        wave_out = '0;
        for (int k = 0; k < NCH; k++) begin
            wave_out[k*OUT_W +: OUT_W] = (smode_q[k] == MODE_SIN) ? sin_s[k] : oth_q[k];
        end
    end

    assign wave_valid = vld2_q;

endmodule

// File: tb/tb_dds_multi_gen.sv
// Directed bench for dds_multi_gen: a per-cycle vector table for reset and
// config timing, then hand-written sequences for periodic waveforms and sync/en/reset.
module tb_dds_multi_gen;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, en, sync;
    logic [15:0] wave_out;
    logic        wave_valid;
    logic [23:0] wave3;
    logic        valid3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dds_multi_gen_if #(.ACC_W(16), .CH_W(1)) cfg ();
    dds_multi_gen_if #(.ACC_W(16), .CH_W(2)) cfg3 ();

    dds_multi_gen #(.ACC_W(16), .OUT_W(8), .LUT_AW(8), .NCH(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .sync(sync), .cfg(cfg),
        .wave_out(wave_out), .wave_valid(wave_valid)
    );

    // Three-channel copy so that a channel number >= NCH is representable.
    dds_multi_gen #(.ACC_W(16), .OUT_W(8), .LUT_AW(8), .NCH(3)) dut3 (
        .clk(clk), .rstn(rstn), .en(en), .sync(sync), .cfg(cfg3),
        .wave_out(wave3), .wave_valid(valid3)
    );

    typedef struct {
        logic        rstn;
        logic        en;
        logic        wr;
        logic        ch;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic        v;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic ch, input logic [1:0] a, input logic [15:0] d);
        cfg.cfg_wr = 1'b1; cfg.cfg_ch = ch; cfg.cfg_addr = a; cfg.cfg_data = d;
        tick();
        cfg.cfg_wr = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] ch, input logic [1:0] a, input logic [15:0] d);
        cfg3.cfg_wr = 1'b1; cfg3.cfg_ch = ch; cfg3.cfg_addr = a; cfg3.cfg_data = d;
        tick();
        cfg3.cfg_wr = 1'b0;
    endtask

    // Clear accumulators with en low, then flush the pipeline so it holds f(0).
    task automatic restart_acc();
        en = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m, e0;
        int s6_w [15];
        int s6_v [15];
        s6_w = '{0, 0, 0, 8, 16, 24, 32, 40, 48, 48, 48, 48, 48, 48, 56};
        s6_v = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};

        //            rstn  en    wr    ch    addr       data      w0     w1     v
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h80, 8'h80, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h80, 8'h80, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, CFG_FREQ,  16'h0000, 8'h80, 8'h80, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, CFG_MODE,  16'h0003, 8'h80, 8'h80, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, CFG_MODE,  16'h0003, 8'h00, 8'h80, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, CFG_PHASE, 16'h8000, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, CFG_FREQ,  16'h0400, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, CFG_FREQ,  16'h0400, 8'h00, 8'h80, 1'b0};

        rstn = 1'b0; en = 1'b0; sync = 1'b0;
        cfg.cfg_wr = 1'b0;  cfg.cfg_ch = 1'b0;  cfg.cfg_addr = 2'd0;  cfg.cfg_data = 16'h0000;
        cfg3.cfg_wr = 1'b0; cfg3.cfg_ch = 2'd0; cfg3.cfg_addr = 2'd0; cfg3.cfg_data = 16'h0000;

        // Reset, sine at DC, valid latency, mode/phase commit timing
        for (int i = 0; i < 11; i++) begin
            rstn = vecs[i].rstn; en = vecs[i].en;
            cfg.cfg_wr = vecs[i].wr; cfg.cfg_ch = vecs[i].ch;
            cfg.cfg_addr = vecs[i].addr; cfg.cfg_data = vecs[i].data;
            tick();
            chk($sformatf("table%0d_w0", i), 32'(wave_out[7:0]), 32'(vecs[i].w0));
            chk($sformatf("table%0d_w1", i), 32'(wave_out[15:8]), 32'(vecs[i].w1));
            chk($sformatf("table%0d_valid", i), 32'(wave_valid), 32'(vecs[i].v));
            if (i == 0) begin
                chk("dut3_reset_wave", 32'(wave3), 32'd0);
                chk("dut3_reset_valid", 32'(valid3), 32'd0);
            end
        end
        cfg.cfg_wr = 1'b0;

        // Saw with wrap on ch0, ch1 offset by half a turn
        en = 1'b1;
        for (int n = 0; n < 130; n++) begin
            tick();
            s  = (n == 0) ? 0 : n - 1;
            e0 = (4 * s) % 256;
            chk("saw_ch0", 32'(wave_out[7:0]), e0);
            chk("saw_ch1_offset", 32'(wave_out[15:8]), (e0 + 128) % 256);
            chk("saw_valid", 32'(wave_valid), 32'(n >= 1));
        end

        // Square with quarter duty, then duty = 0
        en = 1'b0;
        wr(1'b0, CFG_MODE, 16'h0001);
        wr(1'b0, CFG_DUTY, 16'h4000);
        restart_acc();
        en = 1'b1;
        for (int n = 0; n < 130; n++) begin
            tick();
            s = (n == 0) ? 0 : n - 1;
            chk("square_quarter", 32'(wave_out[7:0]), ((s % 64) < 16) ? 32'd255 : 32'd0);
        end
        wr(1'b0, CFG_DUTY, 16'h0000);
        for (int n = 0; n < 70; n++) begin
            tick();
            chk("square_duty0", 32'(wave_out[7:0]), 32'd0);
        end

        // Triangle on ch0, slow sine on ch1
        en = 1'b0;
        wr(1'b0, CFG_MODE, 16'h0002);
        wr(1'b1, CFG_MODE, 16'h0000);
        wr(1'b1, CFG_FREQ, 16'h0100);
        wr(1'b1, CFG_PHASE, 16'h0000);
        restart_acc();
        en = 1'b1;
        for (int n = 0; n < 201; n++) begin
            tick();
            s  = (n == 0) ? 0 : n - 1;
            m  = s % 64;
            e0 = (m < 32) ? 8 * m : 255 - 8 * (m - 32);
            chk("triangle", 32'(wave_out[7:0]), e0);
            if (n == 1)   chk("sine_s0",   32'(wave_out[15:8]), 32'h80);
            if (n == 65)  chk("sine_peak", 32'(wave_out[15:8]), 32'hFF);
            if (n == 129) chk("sine_s128", 32'(wave_out[15:8]), 32'h80);
            if (n == 193) chk("sine_min",  32'(wave_out[15:8]), 32'h01);
        end

        // sync with a simultaneous freq write, then an en gap
        en = 1'b0;
        wr(1'b0, CFG_MODE, 16'h0003);
        wr(1'b0, CFG_FREQ, 16'h0400);
        restart_acc();
        en = 1'b1;
        repeat (10) tick();
        sync = 1'b1;
        cfg.cfg_wr = 1'b1; cfg.cfg_ch = 1'b0; cfg.cfg_addr = CFG_FREQ; cfg.cfg_data = 16'h0800;
        tick();
        sync = 1'b0;
        cfg.cfg_wr = 1'b0;
        for (int k = 1; k < 15; k++) begin
            en = (k >= 7 && k <= 11) ? 1'b0 : 1'b1;
            tick();
            if (k >= 2) begin
                chk($sformatf("sync_en_w%0d", k), 32'(wave_out[7:0]), s6_w[k]);
                chk($sformatf("sync_en_v%0d", k), 32'(wave_valid), s6_v[k]);
            end
        end

        // Reset in the middle of a run
        en = 1'b1;
        rstn = 1'b0;
        tick();
        chk("midrst_wave", 32'(wave_out), 32'd0);
        chk("midrst_valid", 32'(wave_valid), 32'd0);
        rstn = 1'b1;
        tick();
        chk("postrst_wave0", 32'(wave_out), 32'h8080);
        chk("postrst_valid0", 32'(wave_valid), 32'd0);
        tick();
        chk("postrst_wave1", 32'(wave_out), 32'h8080);
        chk("postrst_valid1", 32'(wave_valid), 32'd1);
        tick();
        chk("postrst_wave2", 32'(wave_out), 32'h8080);

        // Writes to an absent channel on the three-channel copy
        en = 1'b0;
        wr3(2'd2, CFG_MODE, 16'h0003);
        wr3(2'd3, CFG_MODE, 16'h0003);
        wr3(2'd3, CFG_PHASE, 16'h4000);
        tick();
        tick();
        chk("dut3_ch0", 32'(wave3[7:0]), 32'h80);
        chk("dut3_ch1", 32'(wave3[15:8]), 32'h80);
        chk("dut3_ch2", 32'(wave3[23:16]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
